// File: rtl/codemasters_ex.sv
// codemasters_ex: CodeMasters-family PRG mapper (mapper 71 / Fire Hawk / mapper 232)
// with an optional M2-cycle IRQ down-counter. All state is clocked on the M2 falling edge.
module codemasters_ex #(
    parameter int MIRRORING_VERTICAL = 1,
    parameter int PRG_BANK_BITS      = 4,
    parameter int FIRE_HAWK_MIRROR   = 1,
    parameter int OUTER_BANK_MODE    = 0,
    parameter int IRQ_ENABLE         = 0
) (
    input  logic         m2,
    input  logic         reset,
    input  logic         romsel,
    input  logic         cpu_rw_in,
    input  logic [14:0]  cpu_addr_in,
    input  logic [7:0]   cpu_data_in,
    output logic [18:12] cpu_addr_out,
    output logic         cpu_rd_out,
    output logic         cpu_wr_out,
    output logic         cpu_flash_ce,
    output logic         cpu_sram_ce,
    input  logic [13:10] ppu_addr_in,
    input  logic         ppu_rd_in,
    input  logic         ppu_wr_in,
    output logic         ppu_rd_out,
    output logic         ppu_wr_out,
    output logic         ppu_sram_ce,
    output logic         ppu_flash_ce,
    output logic         ppu_ciram_a10,
    output logic         ppu_ciram_ce,
    output wire          irq,
    output logic         led
);

    // Outer mode fixes the inner bank at two bits; otherwise it is PRG_BANK_BITS wide.
    localparam bit OUTER_MODE = (OUTER_BANK_MODE != 0);
    localparam int INNER_BITS = OUTER_MODE ? 2 : PRG_BANK_BITS;
    localparam bit FH_ACTIVE  = (FIRE_HAWK_MIRROR != 0) && !OUTER_MODE;
    localparam bit IRQ_ACTIVE = (IRQ_ENABLE != 0) && !OUTER_MODE;

    typedef enum logic [1:0] {
        MIR_HORIZONTAL = 2'b00,
        MIR_VERTICAL   = 2'b01,
        MIR_ONE_LOW    = 2'b10,
        MIR_ONE_HIGH   = 2'b11
    } mir_mode_t;

    localparam mir_mode_t MIR_RESET = (MIRRORING_VERTICAL != 0) ? MIR_VERTICAL : MIR_HORIZONTAL;

    logic [INNER_BITS-1:0] inner_bank;
    logic [1:0]            outer_bank;
    logic [4:0]            inner_ext;
    logic [4:0]            bank_sel;
    mir_mode_t             mir_mode;
    logic [15:0]           irq_reload;
    logic [15:0]           irq_counter;
    logic                  irq_enable;
    logic                  irq_pending;

    // The register file samples on the M2 falling edge, so the "M2 high" part of
    // the write strobe is implied by the clock edge itself.
    logic wr;
    logic [2:0] region;
    assign wr     = ~romsel & ~cpu_rw_in;
    assign region = cpu_addr_in[14:12];

    // Address bits the mapper never decodes.
    logic unused_inputs;
    assign unused_inputs = ^{cpu_addr_in[11:0], ppu_addr_in[12]};

    // Bank registers: $C000-$FFFF loads the inner bank, $8000-$BFFF the outer bank (outer mode only).
    always_ff @(negedge m2 or posedge reset) begin
        if (reset) begin
            inner_bank <= '0;
            outer_bank <= '0;
        end else if (wr) begin
            // NOTE: clocked state uses non-blocking assignments so every register
            // sees the pre-edge values of the others, independent of statement order.
            if (cpu_addr_in[14]) begin
                inner_bank <= cpu_data_in[INNER_BITS-1:0];
            end else if (OUTER_MODE) begin
                outer_bank <= cpu_data_in[4:3];
            end
        end
    end

    // Mirroring mode: hardwired after reset, latched to one-screen by a $9000 write.
    always_ff @(negedge m2 or posedge reset) begin
        if (reset) begin
            mir_mode <= MIR_RESET;
        end else if (FH_ACTIVE && wr && region == 3'b001) begin
            mir_mode <= cpu_data_in[4] ? MIR_ONE_HIGH : MIR_ONE_LOW;
        end
    end

    // IRQ down-counter: register writes take priority over the per-cycle decrement.
    always_ff @(negedge m2 or posedge reset) begin
        if (reset) begin
            irq_reload  <= '0;
            irq_counter <= '0;
            irq_enable  <= 1'b0;
            irq_pending <= 1'b0;
        end else if (IRQ_ACTIVE) begin
            if (wr && region == 3'b010) begin
                irq_reload[7:0] <= cpu_data_in;
            end
            if (wr && region == 3'b011) begin
                irq_reload[15:8] <= cpu_data_in;
                irq_counter      <= {cpu_data_in, irq_reload[7:0]};
                irq_enable       <= 1'b1;
                irq_pending      <= 1'b0;
            end else if (wr && region == 3'b000) begin
                irq_enable  <= 1'b0;
                irq_pending <= 1'b0;
            end else if (irq_enable) begin
                if (irq_counter == 16'd0) begin
                    irq_pending <= 1'b1;
                    irq_enable  <= 1'b0;
                end else begin
                    irq_counter <= irq_counter - 16'd1;
                end
            end
        end
    end

    // Zero-extend the inner bank to the 5-bit flash bank field.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can
        // leave it unassigned and infer a latch.
        inner_ext = '0;
        inner_ext[INNER_BITS-1:0] = inner_bank;
    end

    // PRG bank selection: $C000-$FFFF is pinned to the last bank of the window.
    always_comb begin
        bank_sel = 5'b11111;
        if (OUTER_MODE) begin
            bank_sel = {1'b0, outer_bank, cpu_addr_in[14] ? 2'b11 : inner_ext[1:0]};
        end else if (!cpu_addr_in[14]) begin
            bank_sel = inner_ext;
        end
    end

    // CIRAM A10 source for the current mirroring mode.
    always_comb begin
        ppu_ciram_a10 = ppu_addr_in[10];
        unique case (mir_mode)
            MIR_HORIZONTAL: ppu_ciram_a10 = ppu_addr_in[11];
            MIR_VERTICAL:   ppu_ciram_a10 = ppu_addr_in[10];
            MIR_ONE_LOW:    ppu_ciram_a10 = 1'b0;
            MIR_ONE_HIGH:   ppu_ciram_a10 = 1'b1;
            default:        ppu_ciram_a10 = ppu_addr_in[10];
        endcase
    end

    assign cpu_addr_out = {bank_sel, cpu_addr_in[13:12]};
    assign cpu_rd_out   = ~cpu_rw_in;
    assign cpu_wr_out   = 1'b1;
    assign cpu_flash_ce = romsel;
    assign cpu_sram_ce  = 1'b1;

    assign ppu_rd_out   = ppu_rd_in;
    assign ppu_wr_out   = ppu_wr_in;
    assign ppu_sram_ce  = ppu_addr_in[13];
    assign ppu_flash_ce = 1'b1;
    assign ppu_ciram_ce = ~ppu_addr_in[13];

    // Open-drain: pull low while pending, otherwise release the line.
    assign irq = (IRQ_ACTIVE && irq_pending) ? 1'b0 : 1'bz;
    assign led = ~romsel;

endmodule

// File: doc/codemasters_ex.md
Name: codemasters_ex

Overview:
- Parametrised successor to the CodeMasters (mapper 71) PRG-switching mapper for the cartridge CPLD.
- Covers plain mapper 71, Fire Hawk one-screen mirroring, and BF9096/Quattro (mapper 232) outer banking from one source.
- Adds an optional M2-cycle IRQ timer.
- Sits between the CPU/PPU cartridge buses and the PRG flash and CHR RAM. All register state is clocked from m2.

Parameters:
MIRRORING_VERTICAL, 1, hardwired mirroring after reset (1 = vertical, 0 = horizontal)
PRG_BANK_BITS, 4, width of the switchable 16 KiB bank number, 1..5
FIRE_HAWK_MIRROR, 1, enables the one-screen mirroring register at $9000-$9FFF
OUTER_BANK_MODE, 0, 1 = mapper 232 layout (2-bit outer, 2-bit inner bank)
IRQ_ENABLE, 0, 1 = include the M2 down-counter IRQ (ignored when OUTER_BANK_MODE = 1)

Ports:
m2  input  1  CPU M2; the only clock; state updates on its falling edge
reset  input  1  asynchronous, active-high reset
romsel  input  1  CPU /ROMSEL, low = $8000-$FFFF
cpu_rw_in  input  1  CPU R/W, 0 = write
cpu_addr_in  input  15  CPU A14..A0
cpu_data_in  input  8  CPU data bus
cpu_addr_out  output  7  flash A18..A12
cpu_rd_out, cpu_wr_out, cpu_flash_ce, cpu_sram_ce  output  1 each  flash/SRAM strobes
ppu_addr_in  input  4  PPU A13..A10
ppu_rd_in, ppu_wr_in  input  1 each  PPU strobes
ppu_rd_out, ppu_wr_out, ppu_sram_ce, ppu_flash_ce, ppu_ciram_a10, ppu_ciram_ce  output  1 each  CHR RAM / CIRAM control
irq  output  1  open-drain: 0 when asserted, z otherwise
led  output  1  ~romsel

Behaviour:
- Write strobe `wr`: romsel = 0, cpu_rw_in = 0 and m2 high. It is sampled on the m2 falling edge, giving exactly one commit per CPU cycle.
- Reset values (asynchronous):
  - inner bank = 0, outer bank = 0.
  - Mirroring mode = hardwired {0, MIRRORING_VERTICAL}.
  - IRQ: reload = 0, counter = 0, enable = 0, pending = 0, so irq = z.
- Mid-cycle reset discards any write in progress.
- Standard mode (OUTER_BANK_MODE = 0), PRG map:
  - A14 = 1 ($C000-$FFFF): cpu_addr_out[18:14] = 5'b11111 (last bank).
  - A14 = 0 ($8000-$BFFF): cpu_addr_out[18:14] = inner bank, zero-extended to 5 bits.
  - Write to $C000-$FFFF: inner bank <= data[PRG_BANK_BITS-1:0].
- Outer mode (OUTER_BANK_MODE = 1), PRG map:
  - cpu_addr_out[18:14] = {0, outer[1:0], A14 ? 2'b11 : inner[1:0]}.
  - Write to $8000-$BFFF: outer <= data[4:3].
  - Write to $C000-$FFFF: inner <= data[1:0].
- cpu_addr_out[13:12] = A13..A12 in both modes.
- Fixed strobes:
  - cpu_rd_out = ~cpu_rw_in; cpu_wr_out = 1; cpu_flash_ce = romsel; cpu_sram_ce = 1.
  - ppu_rd_out = ppu_rd_in; ppu_wr_out = ppu_wr_in; ppu_sram_ce = ppu_addr_in[13]; ppu_flash_ce = 1; ppu_ciram_ce = ~ppu_addr_in[13].
- Mirroring:
  - Mode {1, x} gives one-screen: ppu_ciram_a10 = x.
  - Mode {0, 1} is vertical (ppu_addr_in[10]); mode {0, 0} is horizontal (ppu_addr_in[11]).
  - Only when FIRE_HAWK_MIRROR = 1 and OUTER_BANK_MODE = 0: write to $9000-$9FFF sets mode <= {1, data[4]}.
  - Once set, one-screen persists until reset.
- IRQ timer (only when IRQ_ENABLE = 1 and OUTER_BANK_MODE = 0):
  - Write $A000-$AFFF: reload[7:0] <= data.
  - Write $B000-$BFFF: reload[15:8] <= data; counter <= {data, reload[7:0]}; enable <= 1; pending <= 0.
  - Write $8000-$8FFF: enable <= 0; pending <= 0 (acknowledge).
  - On each m2 fall with enable = 1: if counter = 0, then pending <= 1 and enable <= 0; otherwise counter <= counter - 1. There is no wrap.
  - A loaded value N asserts pending on the (N+1)th m2 fall after the load; N = 0 asserts on the first fall.
  - A register write in the same cycle takes priority over decrement or expiry.
  - irq = pending ? 0 : z.
  - When the timer is excluded, irq is constant z and these addresses have no effect.
- Reads never change state. Writes with romsel = 1 are ignored.

Test Plan:
1. Defaults (PRG_BANK_BITS = 4): reset, write $C000 = 8'hF7 -> read at A14 = 0 gives cpu_addr_out[18:14] = 5'b00111; A14 = 1 gives 5'b11111; ppu_ciram_a10 follows ppu_addr_in[10].
2. Fire Hawk: write $9000 = 8'h10 -> ppu_ciram_a10 = 1 for all PPU addresses. Write $9000 = 8'h00 -> 0. Assert reset -> back to vertical.
3. OUTER_BANK_MODE = 1: write $8000 = 8'h18, then $C000 = 8'h02 -> A14 = 0 gives 5'b01110, A14 = 1 gives 5'b01111. A $9000 write leaves mirroring unchanged.
4. IRQ_ENABLE = 1: write $A000 = 8'h03, then $B000 = 8'h00 -> irq goes 0 on the 4th m2 fall after the $B000 commit and stays 0. Write $8000 -> irq = z.
5. IRQ reload while counting: after a load of 100, write $B000 at count 5 -> count restarts from the new value, no IRQ at the old expiry. Assert reset mid-count -> irq = z, counter = 0.
6. PRG_BANK_BITS = 5: write $C000 = 8'hFF -> cpu_addr_out[18:14] = 5'b11111 at A14 = 0. Writes with romsel = 1 or cpu_rw_in = 1 -> bank unchanged.
